// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock set controller: state encoding, key bit indices,
// field limits and a helper that identifies the edit states.
package clock_set_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_SET_HOUR = 3'd1,
      ST_SET_MIN  = 3'd2,
      ST_SET_SEC  = 3'd3,
      ST_COMMIT   = 3'd4
   } state_t;

   localparam int KEY_MODE = 0;
   localparam int KEY_INC  = 1;
   localparam int KEY_DEC  = 2;
   localparam int KEY_EXIT = 3;

   localparam logic [4:0] HOUR_MAX   = 5'd23;
   localparam logic [5:0] MINSEC_MAX = 6'd59;

   function automatic logic is_edit(input state_t s);
      return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
   endfunction

endpackage

// File: rtl/clock_set_ctrl_wrap_step.sv
// wrap_step: one up/down step of a time field that wraps between 0 and max_val.
// Simultaneous inc and dec leave the value unchanged.
module wrap_step #(
   parameter int DATA_W = 6
) (
   input  logic [DATA_W-1:0] value,
   input  logic [DATA_W-1:0] max_val,
   input  logic              inc,
   input  logic              dec,
   output logic [DATA_W-1:0] nxt
);

   always_comb begin
      nxt = value;
      if (inc && !dec)
         nxt = (value == max_val) ? '0 : value + DATA_W'(1);
      else if (dec && !inc)
         nxt = (value == '0) ? max_val : value - DATA_W'(1);
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: key-driven hour/minute/second edit controller with blink and load strobe.
// Optional inactivity timeout is enabled with `define CLOCK_SET_TIMEOUT_EN.
module clock_set_ctrl
   import clock_set_ctrl_pkg::*;
#(
   parameter int TIMEOUT_S = 10,
   parameter int BLINK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_n,
   input  logic       tick_1hz,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic [5:0] set_sec,
   output logic       load,
   output logic [1:0] edit_field,
   output logic       blink
);

   state_t     state, state_nxt;
   logic       ev_exit, ev_mode, ev_inc, ev_dec, ev_step, timeout;
   logic [4:0] hour_nxt;
   logic [5:0] min_nxt, sec_nxt;
   logic [3:0] blink_cnt;

   if (TIMEOUT_S < 1 || TIMEOUT_S > 63) begin : g_bad_timeout
      $error("TIMEOUT_S must be in 1..63");
   end
   if (BLINK_DIV < 1 || BLINK_DIV > 15) begin : g_bad_blink
      $error("BLINK_DIV must be in 1..15");
   end

   // Key decode: EXIT > MODE > INC > DEC, INC+DEC together cancel
   assign ev_exit = !key_n[KEY_EXIT];
   assign ev_mode = !ev_exit && !key_n[KEY_MODE];
   assign ev_inc  = !ev_exit && !ev_mode && !key_n[KEY_INC] &&  key_n[KEY_DEC];
   assign ev_dec  = !ev_exit && !ev_mode &&  key_n[KEY_INC] && !key_n[KEY_DEC];
   assign ev_step = (ev_inc || ev_dec) && is_edit(state);

`ifdef CLOCK_SET_TIMEOUT_EN
   logic [5:0] tmo_cnt;
   logic       key_any;

   // Any key activity wins over an expiring timeout in the same cycle
   assign key_any = (key_n != 4'hF);
   assign timeout = tick_1hz && !key_any && (tmo_cnt == 6'(TIMEOUT_S - 1));

   always_ff @(posedge clk) begin
      if (rst || !is_edit(state) || key_any)
         tmo_cnt <= '0;
      else if (tick_1hz)
         tmo_cnt <= tmo_cnt + 6'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:      if (ev_mode) state_nxt = ST_SET_HOUR;
         ST_SET_HOUR: if (ev_exit) state_nxt = ST_COMMIT;
                      else if (ev_mode) state_nxt = ST_SET_MIN;
                      else if (timeout) state_nxt = ST_RUN;
         ST_SET_MIN:  if (ev_exit) state_nxt = ST_COMMIT;
                      else if (ev_mode) state_nxt = ST_SET_SEC;
                      else if (timeout) state_nxt = ST_RUN;
         ST_SET_SEC:  if (ev_exit || ev_mode) state_nxt = ST_COMMIT;
                      else if (timeout) state_nxt = ST_RUN;
         ST_COMMIT:   state_nxt = ST_RUN;
         default:     state_nxt = ST_RUN;
      endcase
   end

   wrap_step #(.DATA_W(5)) u_hour (
      .value(set_hour), .max_val(HOUR_MAX),
      .inc(ev_inc && state == ST_SET_HOUR), .dec(ev_dec && state == ST_SET_HOUR),
      .nxt(hour_nxt)
   );
   wrap_step #(.DATA_W(6)) u_min (
      .value(set_min), .max_val(MINSEC_MAX),
      .inc(ev_inc && state == ST_SET_MIN), .dec(ev_dec && state == ST_SET_MIN),
      .nxt(min_nxt)
   );
   wrap_step #(.DATA_W(6)) u_sec (
      .value(set_sec), .max_val(MINSEC_MAX),
      .inc(ev_inc && state == ST_SET_SEC), .dec(ev_dec && state == ST_SET_SEC),
      .nxt(sec_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         set_hour  <= '0;
         set_min   <= '0;
         set_sec   <= '0;
         blink     <= 1'b0;
         blink_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_RUN && ev_mode) begin
            set_hour <= cur_hour;
            set_min  <= cur_min;
            set_sec  <= cur_sec;
         end else begin
            set_hour <= hour_nxt;
            set_min  <= min_nxt;
            set_sec  <= sec_nxt;
         end
         // Blink follows the state being entered; a step shows the field solid
         if (!is_edit(state_nxt) || ev_step) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
         end else if (tick_1hz) begin
            if (blink_cnt == 4'(BLINK_DIV - 1)) begin
               blink     <= ~blink;
               blink_cnt <= '0;
            end else begin
               blink_cnt <= blink_cnt + 4'd1;
            end
         end
      end
   end

   always_comb begin
      load       = (state == ST_COMMIT);
      edit_field = 2'd0;
      case (state)
         ST_SET_HOUR: edit_field = 2'd1;
         ST_SET_MIN:  edit_field = 2'd2;
         ST_SET_SEC:  edit_field = 2'd3;
         default:     edit_field = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: directed vector table, multi-cycle sequences and
// randomized traffic compared against a field-level behavioural model.
module tb_clock_set_ctrl;

   localparam int TIMEOUT_S = 10;
   localparam int BLINK_DIV = 1;

   localparam logic [3:0] K_IDLE = 4'b1111;
   localparam logic [3:0] K_MODE = 4'b1110;
   localparam logic [3:0] K_INC  = 4'b1101;
   localparam logic [3:0] K_DEC  = 4'b1011;
   localparam logic [3:0] K_EXIT = 4'b0111;

   logic       clk, rst, tick_1hz, load, blink;
   logic [3:0] key_n;
   logic [4:0] cur_hour, set_hour;
   logic [5:0] cur_min, cur_sec, set_min, set_sec;
   logic [1:0] edit_field;

   clock_set_ctrl #(.TIMEOUT_S(TIMEOUT_S), .BLINK_DIV(BLINK_DIV)) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .tick_1hz(tick_1hz),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .load(load), .edit_field(edit_field), .blink(blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] key;
      logic       tick;
      logic [4:0] ch;
      logic [5:0] cm, cs;
      logic [4:0] eh;
      logic [5:0] em, es;
      logic       eld;
      logic [1:0] eef;
      logic       ebl;
   } vec_t;

   vec_t vt[$];
   int   checks, failures;

   // Model: field 0 = running, 1..3 = editing hour/min/sec, 4 = commit pending
   int m_field, m_h, m_m, m_s, m_blink, m_bcnt, m_tcnt;

   task automatic model_reset();
      m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_blink = 0; m_bcnt = 0; m_tcnt = 0;
   endtask

   task automatic model_step(input logic [3:0] k, input logic t);
      bit ex, md, up, dn, editing;
      int nf;
      ex = !k[3];
      md = !k[0] && !ex;
      up = !k[1] && k[2] && !ex && !md;
      dn = !k[2] && k[1] && !ex && !md;
      editing = (m_field >= 1 && m_field <= 3);
      nf = m_field;
      if (m_field == 0) begin
         if (md) begin
            m_h = int'(cur_hour); m_m = int'(cur_min); m_s = int'(cur_sec); nf = 1;
         end
      end else if (m_field == 4) begin
         nf = 0;
      end else if (ex) begin
         nf = 4;
      end else if (md) begin
         nf = m_field + 1;
      end else if (up || dn) begin
         case (m_field)
            1: m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
            2: m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
            default: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
         endcase
      end
`ifdef CLOCK_SET_TIMEOUT_EN
      else if (t && m_tcnt + 1 >= TIMEOUT_S) begin
         nf = 0;
      end
      if (!editing || k != 4'hF) m_tcnt = 0;
      else if (t) m_tcnt = m_tcnt + 1;
`endif
      if (!(nf >= 1 && nf <= 3) || (editing && (up || dn))) begin
         m_blink = 0; m_bcnt = 0;
      end else if (t) begin
         m_bcnt = m_bcnt + 1;
         if (m_bcnt == BLINK_DIV) begin
            m_blink = 1 - m_blink; m_bcnt = 0;
         end
      end
      m_field = nf;
   endtask

   task automatic check(input string name, input logic [4:0] eh, input logic [5:0] em,
                        input logic [5:0] es, input logic eld, input logic [1:0] eef,
                        input logic ebl);
      checks++;
      if ({set_hour, set_min, set_sec, load, edit_field, blink} !== {eh, em, es, eld, eef, ebl}) begin
         failures++;
         $display("FAIL %s: got %0d:%0d:%0d load=%0b field=%0d blink=%0b, expected %0d:%0d:%0d load=%0b field=%0d blink=%0b",
                  name, set_hour, set_min, set_sec, load, edit_field, blink, eh, em, es, eld, eef, ebl);
      end
   endtask

   task automatic check_model(input string name);
      logic [1:0] ef;
      ef = (m_field >= 1 && m_field <= 3) ? 2'(m_field) : 2'd0;
      check(name, 5'(m_h), 6'(m_m), 6'(m_s), m_field == 4, ef, m_blink != 0);
   endtask

   task automatic step(input logic [3:0] k, input logic t);
      key_n = k;
      tick_1hz = t;
      @(posedge clk);
      #1;
      model_step(k, t);
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1; key_n = K_IDLE; tick_1hz = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check(name, 5'd0, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic add(input logic [3:0] k, input logic t, input int ch, input int cm, input int cs,
                      input int eh, input int em, input int es, input logic eld,
                      input int eef, input logic ebl);
      vec_t v;
      v.key = k; v.tick = t; v.ch = 5'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
      v.eh = 5'(eh); v.em = 6'(em); v.es = 6'(es); v.eld = eld; v.eef = 2'(eef); v.ebl = ebl;
      vt.push_back(v);
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; key_n = K_IDLE; tick_1hz = 1'b0;
      cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
      model_reset();

      // key, tick, cur h:m:s, expected h:m:s, load, field, blink
      add(K_MODE, 0, 12,34,56, 12,34,56, 0,1,0);
      add(K_IDLE, 0, 12,34,56, 12,34,56, 0,1,0);
      add(K_MODE, 0, 12,34,56, 12,34,56, 0,2,0);
      add(K_INC,  0, 12,34,56, 12,35,56, 0,2,0);
      add(K_INC,  0, 12,34,56, 12,36,56, 0,2,0);
      add(K_INC,  0, 12,34,56, 12,37,56, 0,2,0);
      add(K_EXIT, 0, 12,34,56, 12,37,56, 1,0,0);
      add(K_IDLE, 0, 12,34,56, 12,37,56, 0,0,0);
      add(K_IDLE, 1, 12,34,56, 12,37,56, 0,0,0);
      add(K_INC,  0, 12,34,56, 12,37,56, 0,0,0);
      add(K_EXIT, 0, 12,34,56, 12,37,56, 0,0,0);
      add(K_MODE, 0, 12,34,56, 12,34,56, 0,1,0);
      add(K_MODE, 0, 12,34,56, 12,34,56, 0,2,0);
      add(4'b0101,0, 12,34,56, 12,34,56, 1,0,0);
      add(K_IDLE, 0, 12,34,56, 12,34,56, 0,0,0);
      add(K_MODE, 0, 23, 0, 0, 23, 0, 0, 0,1,0);
      add(K_INC,  0, 23, 0, 0,  0, 0, 0, 0,1,0);
      add(K_DEC,  0, 23, 0, 0, 23, 0, 0, 0,1,0);
      add(K_MODE, 0, 23, 0, 0, 23, 0, 0, 0,2,0);
      add(K_DEC,  0, 23, 0, 0, 23,59, 0, 0,2,0);
      add(K_INC,  0, 23, 0, 0, 23, 0, 0, 0,2,0);
      add(4'b1001,0, 23, 0, 0, 23, 0, 0, 0,2,0);
      add(K_DEC,  0, 23, 0, 0, 23,59, 0, 0,2,0);
      add(K_IDLE, 1, 23, 0, 0, 23,59, 0, 0,2,1);
      add(K_IDLE, 1, 23, 0, 0, 23,59, 0, 0,2,0);
      add(K_IDLE, 1, 23, 0, 0, 23,59, 0, 0,2,1);
      add(K_IDLE, 0, 23, 0, 0, 23,59, 0, 0,2,1);
      add(K_DEC,  0, 23, 0, 0, 23,58, 0, 0,2,0);
      add(K_IDLE, 1, 23, 0, 0, 23,58, 0, 0,2,1);
      add(K_INC,  0, 23, 0, 0, 23,59, 0, 0,2,0);
      add(K_MODE, 0, 23, 0, 0, 23,59, 0, 0,3,0);
      add(K_DEC,  0, 23, 0, 0, 23,59,59, 0,3,0);
      add(K_INC,  0, 23, 0, 0, 23,59, 0, 0,3,0);
      add(K_EXIT, 0, 23, 0, 0, 23,59, 0, 1,0,0);
      add(K_IDLE, 0, 23, 0, 0, 23,59, 0, 0,0,0);

      repeat (2) @(posedge clk);
      #1;
      do_reset("reset_state");

      for (int i = 0; i < vt.size(); i++) begin
         cur_hour = vt[i].ch; cur_min = vt[i].cm; cur_sec = vt[i].cs;
         step(vt[i].key, vt[i].tick);
         check($sformatf("vec%0d", i), vt[i].eh, vt[i].em, vt[i].es, vt[i].eld, vt[i].eef, vt[i].ebl);
      end

      // Reset in the middle of an edit discards it without a load
      cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
      step(K_MODE, 1'b0);
      step(K_MODE, 1'b0);
      step(K_MODE, 1'b0);
      check("in_set_sec", 5'd12, 6'd34, 6'd56, 1'b0, 2'd3, 1'b0);
      do_reset("reset_mid_edit");
      step(K_IDLE, 1'b0);
      check("after_mid_reset", 5'd0, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0);

`ifdef CLOCK_SET_TIMEOUT_EN
      step(K_MODE, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(K_IDLE, 1'b1);
         check_model($sformatf("tmo_pre%0d", i));
      end
      step(K_INC, 1'b1);
      check("tmo_key_at_9", 5'd13, 6'd34, 6'd56, 1'b0, 2'd1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         step(K_IDLE, 1'b1);
         check_model($sformatf("tmo_post%0d", i));
      end
      check("tmo_still_edit", set_hour, set_min, set_sec, 1'b0, 2'd1, blink);
      step(K_IDLE, 1'b1);
      check("tmo_expired", 5'd13, 6'd34, 6'd56, 1'b0, 2'd0, 1'b0);
      step(K_IDLE, 1'b0);
      check("tmo_no_load", 5'd13, 6'd34, 6'd56, 1'b0, 2'd0, 1'b0);
`endif

      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [3:0] k;
         cur_hour = 5'($urandom_range(0, 23));
         cur_min  = 6'($urandom_range(0, 59));
         cur_sec  = 6'($urandom_range(0, 59));
         if ($urandom_range(0, 499) == 0) begin
            do_reset($sformatf("rand_reset%0d", n));
         end else begin
            r = $urandom_range(0, 9);
            case (r)
               5:       k = K_MODE;
               6:       k = K_INC;
               7:       k = K_DEC;
               8:       k = ($urandom_range(0, 3) == 0) ? K_EXIT : K_MODE;
               9:       k = 4'($urandom_range(0, 15));
               default: k = K_IDLE;
            endcase
            step(k, $urandom_range(0, 3) == 0);
            check_model($sformatf("rand%0d", n));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 10: number of inactive seconds before edit mode is abandoned (range 1..63).
REQ-002 SHALL have parameter BLINK_DIV, default 1: number of tick_1hz pulses per blink toggle (range 1..15).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port key_n  input  4  debounced key events, active-low; 4'b1111 is idle; each cycle a bit is 0 counts as one press event. [0]=MODE, [1]=INC, [2]=DEC, [3]=EXIT.
REQ-006 SHALL have port tick_1hz  input  1  one-cycle pulse once per second.
REQ-007 SHALL have ports cur_hour/cur_min/cur_sec  input  5/6/6  running time from the timekeeper.
REQ-008 SHALL have ports set_hour/set_min/set_sec  output  5/6/6  edit shadow registers.
REQ-009 SHALL have port load  output  1  one-cycle strobe; the timekeeper copies set_* on this cycle.
REQ-010 SHALL have port edit_field  output  2  0=none, 1=hour, 2=minute, 3=second.
REQ-011 SHALL have port blink  output  1  display blank request for the field being edited.

Function
REQ-012 SHALL implement states RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
REQ-013 SHALL decode one event per cycle with priority EXIT > MODE > INC > DEC; INC and DEC low in the same cycle SHALL be ignored.
REQ-014 In RUN, MODE SHALL copy cur_* into set_* and enter SET_HOUR on the next edge; INC, DEC and EXIT SHALL have no effect.
REQ-015 MODE SHALL advance SET_HOUR->SET_MIN->SET_SEC->COMMIT.
REQ-016 EXIT in any SET_* state SHALL go to COMMIT.
REQ-017 COMMIT SHALL assert load for exactly one cycle, then return to RUN; load is 0 in every other state.
REQ-018 INC/DEC SHALL modify only the active field: hour wraps 23->0 and 0->23; minute and second wrap 59->0 and 0->59; the update is visible on the cycle after the event.
REQ-019 A held key (repeated low cycles from the debouncer) SHALL act as auto-repeat, one step per low cycle.
REQ-020 edit_field SHALL be 1/2/3 in SET_HOUR/SET_MIN/SET_SEC and 0 in RUN and COMMIT.
REQ-021 blink SHALL toggle every BLINK_DIV tick_1hz pulses while in a SET_* state, SHALL be forced to 0 (field visible) on the cycle after any INC/DEC, and SHALL be 0 in RUN and COMMIT.
REQ-022 set_* SHALL hold their values in RUN.

Reset
REQ-023 rst SHALL force state RUN, set_*=0, load=0, edit_field=0, blink=0, and clear the blink and timeout counters; reset in mid-edit SHALL discard the edit without a load.

Configuration
REQ-024 With macro CLOCK_SET_TIMEOUT_EN defined, a counter SHALL increment on each tick_1hz in SET_* states and clear on any key event; on reaching TIMEOUT_S it SHALL return to RUN without a load, discarding the edit.
REQ-025 With CLOCK_SET_TIMEOUT_EN undefined, no timeout logic SHALL exist and edit mode SHALL persist until EXIT or MODE out of SET_SEC.
REQ-026 A key event and the timeout in the same cycle SHALL be resolved in favour of the key event.

Structure
REQ-027 A shared package SHALL hold the state encoding, the key-bit index constants (KEY_MODE=0, KEY_INC=1, KEY_DEC=2, KEY_EXIT=3), and the field limits HOUR_MAX=23 and MINSEC_MAX=59.
REQ-028 The wrap-around up/down step SHALL be a sub-module wrap_step (value, max, inc, dec -> next value), instantiated once per field.

Verification
REQ-029 cur=12:34:56, MODE pulse -> set_*=12:34:56, edit_field=1 on the next cycle.
REQ-030 In SET_HOUR at 23, INC -> set_hour=0; in SET_MIN at 0, DEC -> set_min=59.
REQ-031 Sequence MODE, MODE, INC x3 (set_min 34->37), EXIT -> load high for exactly one cycle with set_min=37, then state RUN, edit_field=0.
REQ-032 key_n=4'b0101 (EXIT and INC both active) in SET_MIN -> COMMIT taken, set_min unchanged.
REQ-033 With CLOCK_SET_TIMEOUT_EN, enter SET_HOUR, then 10 tick_1hz pulses with no key -> RUN, load never asserted; a key event at tick 9 restarts the count.
REQ-034 rst asserted in SET_SEC -> next cycle state RUN, set_*=0, load=0, blink=0.
